// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_pkg
// Brief    : Shared types and width helpers for the cpumc bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

  // Index width that stays legal (>=1) for a single master or slave.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sysbus_if.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_if
// Brief    : Master- and slave-side signals of the cpumc arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sysbus_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int AW          = 16,
  parameter int DW          = 8
) ();

  logic [NUM_MASTERS-1:0]    m_req_in;
  logic [NUM_MASTERS-1:0]    m_lock_in;
  logic [NUM_MASTERS*AW-1:0] m_a_in;
  logic [NUM_MASTERS-1:0]    m_r_nw_in;
  logic [NUM_MASTERS*DW-1:0] m_d_in;
  logic [NUM_MASTERS-1:0]    m_gnt_out;
  logic [NUM_MASTERS-1:0]    m_rdy_out;
  logic [DW-1:0]             m_d_out;
  logic                      err_out;
  logic [NUM_SLAVES-1:0]     s_en_out;
  logic [AW-1:0]             s_a_out;
  logic                      s_r_nw_out;
  logic [DW-1:0]             s_d_out;
  logic [NUM_SLAVES*DW-1:0]  s_d_in;

  // The arbiter is the target of the master requests: it takes the slave view.
  modport slave (
    input  m_req_in, m_lock_in, m_a_in, m_r_nw_in, m_d_in, s_d_in,
    output m_gnt_out, m_rdy_out, m_d_out, err_out,
           s_en_out, s_a_out, s_r_nw_out, s_d_out
  );

  modport master (
    output m_req_in, m_lock_in, m_a_in, m_r_nw_in, m_d_in, s_d_in,
    input  m_gnt_out, m_rdy_out, m_d_out, err_out,
           s_en_out, s_a_out, s_r_nw_out, s_d_out
  );

endinterface
`default_nettype wire

// File: rtl/sysbus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_rr_pick
// Brief    : One-hot winner search starting at i_start (index 0 in fixed mode).
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_rr_pick #(
  parameter int N       = 2,
  parameter int RR_MODE = 0,
  parameter int IW      = 1
) (
  input  wire logic [N-1:0]  i_req,
  input  wire logic [IW-1:0] i_start,
  output logic      [N-1:0]  o_gnt
);

  always_comb begin
    logic found;
    int   base;
    int   idx;
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    base  = (RR_MODE != 0) ? int'(i_start) : 0;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_arbiter
// Brief    : N-master / M-slave cpumc bus arbiter with lock and mask/base decode.
// Revision : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int RR_MODE     = 0,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = {16'h8000, 16'h2000, 16'h0000},
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = {16'h8000, 16'hE000, 16'hE000}
) (
  input wire logic clk_in,
  input wire logic nrst_in,
  sysbus_if.slave  bus
);

  localparam int MIDX_W = idx_w(NUM_MASTERS);
  localparam logic [MIDX_W-1:0] C_LAST = MIDX_W'(NUM_MASTERS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [MIDX_W-1:0]       r_owner;
  logic [MIDX_W-1:0]       r_last_gnt;
  logic [MIDX_W-1:0]       r_lock_owner;
  logic                    r_lock_vld;
  logic [AW-1:0]           r_a;
  logic                    r_rnw;
  logic [DW-1:0]           r_d;
  logic [DW-1:0]           r_hold;
  logic [NUM_SLAVES-1:0]   r_sel;

  logic                    w_lock_act;
  logic [NUM_MASTERS-1:0]  w_elig;
  logic [NUM_MASTERS-1:0]  w_win;
  logic [MIDX_W-1:0]       w_start;
  logic [MIDX_W-1:0]       w_win_idx;
  logic [AW-1:0]           w_win_a;
  logic                    w_win_rnw;
  logic [DW-1:0]           w_win_d;
  logic                    w_win_lock;
  logic [NUM_SLAVES-1:0]   w_hit;
  logic [NUM_SLAVES-1:0]   w_hit_below;
  logic [NUM_SLAVES-1:0]   w_sel;
  logic [DW-1:0]           w_rd_term [NUM_SLAVES];
  logic [DW-1:0]           w_rd_data;
  logic [NUM_MASTERS-1:0]  w_owner_oh;

  // A held lock masks every other requester; once the owner lets go of its
  // lock input the normal search resumes in the same IDLE cycle.
  assign w_lock_act = r_lock_vld && bus.m_lock_in[r_lock_owner];

  always_comb begin
    w_elig = bus.m_req_in;
    if (w_lock_act) begin
      w_elig = '0;
      w_elig[r_lock_owner] = bus.m_req_in[r_lock_owner];
    end
  end

  assign w_start = (r_last_gnt == C_LAST) ? '0 : r_last_gnt + 1'b1;

  sysbus_rr_pick #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE),
    .IW      (MIDX_W)
  ) u_pick (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_gnt   (w_win)
  );

  always_comb begin
    w_win_idx  = '0;
    w_win_a    = '0;
    w_win_rnw  = 1'b1;
    w_win_d    = '0;
    w_win_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win[i]) begin
        w_win_idx  = MIDX_W'(i);
        w_win_a    = bus.m_a_in[i*AW +: AW];
        w_win_rnw  = bus.m_r_nw_in[i];
        w_win_d    = bus.m_d_in[i*DW +: DW];
        w_win_lock = bus.m_lock_in[i];
      end
    end
  end

  // Lowest-index hit wins where slave windows overlap.
  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
    assign w_hit[s] = (w_win_a & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW];
    if (s == 0) begin : g_first
      assign w_hit_below[s] = 1'b0;
    end else begin : g_rest
      assign w_hit_below[s] = w_hit_below[s-1] | w_hit[s-1];
    end
    assign w_sel[s] = w_hit[s] & ~w_hit_below[s];
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_rd
    assign w_rd_term[s] = bus.s_d_in[s*DW +: DW] & {DW{r_sel[s]}};
  end

  always_comb begin
    w_rd_data = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_rd_data = w_rd_data | w_rd_term[s];
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|w_win) w_state_nxt = ST_ADDR;
      ST_ADDR: w_state_nxt = ST_DATA;
      ST_DATA: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_owner      <= '0;
      r_last_gnt   <= C_LAST;
      r_lock_owner <= '0;
      r_lock_vld   <= 1'b0;
      r_a          <= '0;
      r_rnw        <= 1'b1;
      r_d          <= '0;
      r_hold       <= '0;
      r_sel        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_win) begin
            r_owner    <= w_win_idx;
            r_last_gnt <= w_win_idx;
            r_a        <= w_win_a;
            r_rnw      <= w_win_rnw;
            r_d        <= w_win_d;
            r_sel      <= w_sel;
          end
          if ((|w_win) && w_win_lock) begin
            r_lock_vld   <= 1'b1;
            r_lock_owner <= w_win_idx;
          end else if (r_lock_vld && !bus.m_lock_in[r_lock_owner]) begin
            r_lock_vld   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (r_rnw) r_hold <= w_rd_data;
        end
        default: ;
      endcase
    end
  end

  assign w_owner_oh     = NUM_MASTERS'(1) << r_owner;
  assign bus.m_gnt_out  = (r_state == ST_ADDR) ? w_owner_oh : '0;
  assign bus.m_rdy_out  = (r_state == ST_DATA) ? w_owner_oh : '0;
  assign bus.s_en_out   = (r_state == ST_ADDR) ? r_sel : '0;
  assign bus.err_out    = (r_state == ST_DATA) && (r_sel == '0);
  assign bus.m_d_out    = ((r_state == ST_DATA) && r_rnw) ? w_rd_data : r_hold;
  assign bus.s_a_out    = r_a;
  assign bus.s_r_nw_out = r_rnw;
  assign bus.s_d_out    = r_d;

endmodule
`default_nettype wire
